// File: rtl/gcd_host_sequencer.sv
// ---------------------------------------------------------------------------
// gcd_host_sequencer
//
// Initiator-side driver for the GCD datapath/controller pair. A host hands
// over an operand pair on a valid/ready request port; the sequencer raises
// gcd_start, walks A and then B onto the core's shared data bus, waits for
// gcd_done and returns the core's A-register result on a valid/ready response
// port. Zero operands are rejected without touching the core, and a core that
// never raises done is abandoned after TIMEOUT wait cycles so the host never
// hangs.
//
// Parameters
//   WIDTH       operand/result width, matches the core data bus
//   START_LEAD  cycles gcd_start is high with a zero bus before A (>= 1)
//   TIMEOUT     wait cycles before the core is declared hung (>= 2)
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   req_valid_i    operand pair valid
//   req_ready_o    sequencer can accept a pair (IDLE and core done low)
//   req_a_i        operand A
//   req_b_i        operand B
//   rsp_valid_o    result valid
//   rsp_ready_i    host accepts the result
//   rsp_gcd_o      GCD result, 0 on error
//   rsp_err_o      1 = zero operand or timeout
//   rsp_cycles_o   wait cycles spent, saturating at 16'hFFFF
//   gcd_start_o    start to the core controller
//   gcd_data_o     core data_in bus
//   gcd_done_i     core done
//   gcd_result_i   core A-register output
// ---------------------------------------------------------------------------
module gcd_host_sequencer #(
    parameter int WIDTH      = 16,
    parameter int START_LEAD = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_gcd_o,
    output logic             rsp_err_o,
    output logic [15:0]      rsp_cycles_o,
    output logic             gcd_start_o,
    output logic [WIDTH-1:0] gcd_data_o,
    input  logic             gcd_done_i,
    input  logic [WIDTH-1:0] gcd_result_i
);

    localparam int                LEAD_W    = (START_LEAD > 1) ? $clog2(START_LEAD) : 1;
    localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(START_LEAD - 1);

    // The wait counter saturates at 16 bits, so a larger TIMEOUT could never
    // be reached; clamp it so a hung core is still released.
    localparam int          TIMEOUT_EFF = (TIMEOUT > 65535) ? 65535 : TIMEOUT;
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_EFF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q,  state_d;
    logic [WIDTH-1:0]  opA_q,    opA_d;
    logic [WIDTH-1:0]  opB_q,    opB_d;
    logic [WIDTH-1:0]  rspGcd_q, rspGcd_d;
    logic              rspErr_q, rspErr_d;
    logic [15:0]       cycles_q, cycles_d;
    logic [LEAD_W-1:0] leadCnt_q, leadCnt_d;

    logic [15:0]       cycleInc;
    logic              reqZero;

    // The wait counter doubles as the reported cycle count, so it is only
    // ever written on accept (cleared) and while waiting (incremented).
    assign cycleInc = (cycles_q == 16'hFFFF) ? cycles_q : (cycles_q + 16'd1);
    assign reqZero  = (req_a_i == '0) || (req_b_i == '0);

    // State and datapath registers; reset abandons any core operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            opA_q     <= '0;
            opB_q     <= '0;
            rspGcd_q  <= '0;
            rspErr_q  <= 1'b0;
            cycles_q  <= '0;
            leadCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            rspGcd_q  <= rspGcd_d;
            rspErr_q  <= rspErr_d;
            cycles_q  <= cycles_d;
            leadCnt_q <= leadCnt_d;
        end
    end

    // Next-state logic. Accept is gated on done being low so a core still
    // showing done from the previous run sees start low before a restart.
    // In WAIT a done sample takes priority over an expiring timeout.
    always_comb begin
        state_d   = state_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        rspGcd_d  = rspGcd_q;
        rspErr_d  = rspErr_q;
        cycles_d  = cycles_q;
        leadCnt_d = leadCnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && !gcd_done_i) begin
                    opA_d     = req_a_i;
                    opB_d     = req_b_i;
                    rspGcd_d  = '0;
                    rspErr_d  = 1'b0;
                    cycles_d  = '0;
                    leadCnt_d = '0;
                    if (reqZero) begin
                        rspErr_d = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_LEAD;
                    end
                end
            end
            S_LEAD: begin
                if (leadCnt_q == LEAD_LAST) begin
                    state_d = S_LOAD_A;
                end else begin
                    leadCnt_d = leadCnt_q + LEAD_W'(1);
                end
            end
            S_LOAD_A: begin
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cycles_d = cycleInc;
                if (gcd_done_i) begin
                    rspGcd_d = gcd_result_i;
                    rspErr_d = 1'b0;
                    state_d  = S_RESP;
                end else if (cycleInc >= TIMEOUT_CNT) begin
                    rspGcd_d = '0;
                    rspErr_d = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Core-side and handshake outputs decoded from state so that an async
    // reset drops gcd_start in the same cycle. The bus keeps B through WAIT.
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        gcd_start_o = 1'b0;
        gcd_data_o  = '0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = ~gcd_done_i;
            end
            S_LEAD: begin
                gcd_start_o = 1'b1;
            end
            S_LOAD_A: begin
                gcd_start_o = 1'b1;
                gcd_data_o  = opA_q;
            end
            S_LOAD_B, S_WAIT: begin
                gcd_start_o = 1'b1;
                gcd_data_o  = opB_q;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

    assign rsp_gcd_o    = rspGcd_q;
    assign rsp_err_o    = rspErr_q;
    assign rsp_cycles_o = cycles_q;

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gcd_host_sequencer
//
// Drives gcd_host_sequencer against a behavioural GCD core. The core samples
// the data bus while start is high (lead zeros, then A, then B), raises done
// a programmable number of cycles after taking B, and keeps done high until
// start has been low for a programmable number of cycles. Expected results
// come from a plain Euclid reference and from the handshake timing rules.
// ---------------------------------------------------------------------------
module tb_gcd_host_sequencer;

    localparam int WIDTH = 16;
    localparam int SL    = 1;
    localparam int TO    = 8;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              reqValid = 1'b0;
    logic              reqReady;
    logic [WIDTH-1:0]  reqA     = '0;
    logic [WIDTH-1:0]  reqB     = '0;
    logic              rspValid;
    logic              rspReady = 1'b0;
    logic [WIDTH-1:0]  rspGcd;
    logic              rspErr;
    logic [15:0]       rspCycles;
    logic              gcdStart;
    logic [WIDTH-1:0]  gcdData;
    logic              gcdDone;
    logic [WIDTH-1:0]  gcdResult;

    int checks   = 0;
    int failures = 0;

    // Behavioural core controls and state
    int               coreDelay  = 1;
    bit               coreHang   = 1'b0;
    int               coreLinger = 0;
    logic [WIDTH-1:0] dataLog[$];
    int               samples    = 0;
    int               sinceB     = -1;
    int               lingerCnt  = 0;
    logic [WIDTH-1:0] lastData   = '0;
    logic [WIDTH-1:0] coreA      = '0;
    logic [WIDTH-1:0] coreB      = '0;

    gcd_host_sequencer #(
        .WIDTH      (WIDTH),
        .START_LEAD (SL),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_a_i      (reqA),
        .req_b_i      (reqB),
        .rsp_valid_o  (rspValid),
        .rsp_ready_i  (rspReady),
        .rsp_gcd_o    (rspGcd),
        .rsp_err_o    (rspErr),
        .rsp_cycles_o (rspCycles),
        .gcd_start_o  (gcdStart),
        .gcd_data_o   (gcdData),
        .gcd_done_i   (gcdDone),
        .gcd_result_i (gcdResult)
    );

    always #5 clk = ~clk;

    // Euclid by remainders, the textbook definition of the result
    function automatic logic [WIDTH-1:0] refGcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] t;
        a = x;
        b = y;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural core: logs the bus while start is high, answers coreDelay
    // cycles after B, and lets done linger after start falls.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            samples   = 0;
            sinceB    = -1;
            lingerCnt = 0;
            gcdDone   <= 1'b0;
            gcdResult <= '0;
        end else if (gcdStart === 1'b1) begin
            lingerCnt = coreLinger;
            if (samples < SL + 2) begin
                dataLog.push_back(gcdData);
                samples++;
                if (samples == SL + 2) begin
                    coreA  = lastData;
                    coreB  = gcdData;
                    sinceB = 0;
                end
                lastData = gcdData;
            end else if (sinceB >= 0) begin
                sinceB++;
                if (sinceB == coreDelay && !coreHang) begin
                    gcdDone   <= 1'b1;
                    gcdResult <= refGcd(coreA, coreB);
                end
            end
        end else begin
            samples = 0;
            sinceB  = -1;
            if (gcdDone) begin
                if (lingerCnt == 0) gcdDone <= 1'b0;
                else lingerCnt--;
            end
        end
    end

    // Offers a pair once the sequencer is ready, scrambles the request bus
    // after the handshake and waits for the response (rsp_ready left low).
    task automatic doTxn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] g, output logic e, output logic [15:0] cyc,
                         output int lat, output bit hung, output bit sawStart, output bit readyLeak);
        int k;
        hung = 1'b0; sawStart = 1'b0; readyLeak = 1'b0; lat = 0;
        g = '0; e = 1'b0; cyc = '0;
        dataLog.delete();
        k = 0;
        while (reqReady !== 1'b1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (reqReady !== 1'b1) begin
            hung = 1'b1;
            return;
        end
        reqValid = 1'b1; reqA = a; reqB = b;
        @(posedge clk); #1;
        reqValid = 1'b0; reqA = WIDTH'($urandom); reqB = WIDTH'($urandom);
        while (rspValid !== 1'b1 && lat < 100) begin
            if (gcdStart === 1'b1) sawStart = 1'b1;
            if (reqReady !== 1'b0) readyLeak = 1'b1;
            @(posedge clk); #1; lat++;
        end
        lat++;
        if (rspValid !== 1'b1) begin
            hung = 1'b1;
            return;
        end
        if (reqReady !== 1'b0) readyLeak = 1'b1;
        g = rspGcd; e = rspErr; cyc = rspCycles;
    endtask

    task automatic finishRsp();
        rspReady = 1'b1;
        @(posedge clk); #1;
        rspReady = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (reqReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready: got %b expected 1", reqReady); end
        checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rspValid); end
        checks++; if (gcdStart !== 1'b0) begin failures++; $display("[TB] FAIL reset_gcd_start: got %b expected 0", gcdStart); end
        checks++; if (gcdData !== '0) begin failures++; $display("[TB] FAIL reset_gcd_data: got %0d expected 0", gcdData); end
        checks++; if (rspGcd !== '0) begin failures++; $display("[TB] FAIL reset_rsp_gcd: got %0d expected 0", rspGcd); end
        checks++; if (rspErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rspErr); end
        checks++; if (rspCycles !== 16'd0) begin failures++; $display("[TB] FAIL reset_rsp_cycles: got %0d expected 0", rspCycles); end
    endtask

    task automatic test_normal();
        logic [WIDTH-1:0] g;
        logic [15:0]      cyc;
        logic             e;
        int               lat;
        int               d;
        bit               hung, sawStart, leak;
        d = $urandom_range(1, 5);
        coreDelay = d;
        doTxn(16'd143, 16'd78, g, e, cyc, lat, hung, sawStart, leak);
        checks++; if (hung) begin failures++; $display("[TB] FAIL normal_done: response got none expected one within bound"); end
        checks++; if (g !== 16'd13) begin failures++; $display("[TB] FAIL normal_gcd: got %0d expected 13", g); end
        checks++; if (e !== 1'b0) begin failures++; $display("[TB] FAIL normal_err: got %b expected 0", e); end
        checks++; if (lat !== SL + 2 + (d + 1) + 1) begin failures++; $display("[TB] FAIL normal_latency: got %0d expected %0d", lat, SL + 2 + (d + 1) + 1); end
        checks++; if (cyc !== 16'(d + 1)) begin failures++; $display("[TB] FAIL normal_cycles: got %0d expected %0d", cyc, d + 1); end
        checks++; if (leak) begin failures++; $display("[TB] FAIL normal_req_ready_busy: got 1 expected 0"); end
        checks++; if (dataLog.size() !== SL + 2) begin
            failures++; $display("[TB] FAIL normal_bus_length: got %0d expected %0d", dataLog.size(), SL + 2);
        end else begin
            for (int i = 0; i < SL; i++) begin
                checks++; if (dataLog[i] !== '0) begin failures++; $display("[TB] FAIL normal_bus_lead: got %0d expected 0", dataLog[i]); end
            end
            checks++; if (dataLog[SL] !== 16'd143) begin failures++; $display("[TB] FAIL normal_bus_a: got %0d expected 143", dataLog[SL]); end
            checks++; if (dataLog[SL + 1] !== 16'd78) begin failures++; $display("[TB] FAIL normal_bus_b: got %0d expected 78", dataLog[SL + 1]); end
        end
        finishRsp();
        checks++; if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
            failures++; $display("[TB] FAIL normal_release: got valid=%b ready=%b expected valid=0 ready=1", rspValid, reqReady);
        end
    endtask

    task automatic test_zero_operands();
        logic [WIDTH-1:0] as[2];
        logic [WIDTH-1:0] bs[2];
        logic [WIDTH-1:0] g;
        logic [15:0]      cyc;
        logic             e;
        int               lat;
        bit               hung, sawStart, leak;
        as[0] = 16'd0;  bs[0] = 16'd55;
        as[1] = 16'd55; bs[1] = 16'd0;
        for (int i = 0; i < 2; i++) begin
            doTxn(as[i], bs[i], g, e, cyc, lat, hung, sawStart, leak);
            checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL zero_latency[%0d]: got %0d expected 1", i, lat); end
            checks++; if (e !== 1'b1) begin failures++; $display("[TB] FAIL zero_err[%0d]: got %b expected 1", i, e); end
            checks++; if (g !== '0) begin failures++; $display("[TB] FAIL zero_gcd[%0d]: got %0d expected 0", i, g); end
            checks++; if (cyc !== 16'd0) begin failures++; $display("[TB] FAIL zero_cycles[%0d]: got %0d expected 0", i, cyc); end
            checks++; if (sawStart || gcdStart !== 1'b0 || dataLog.size() != 0) begin
                failures++; $display("[TB] FAIL zero_no_start[%0d]: got start seen expected core untouched", i);
            end
            finishRsp();
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] g;
        logic [15:0]      cyc;
        logic             e;
        int               lat;
        bit               hung, sawStart, leak;
        coreDelay = $urandom_range(1, 5);
        doTxn(16'd21, 16'd21, g, e, cyc, lat, hung, sawStart, leak);
        checks++; if (g !== 16'd21 || e !== 1'b0) begin failures++; $display("[TB] FAIL b2b_first: got gcd=%0d err=%b expected gcd=21 err=0", g, e); end
        finishRsp();
        checks++; if (reqReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready: got %b expected 1", reqReady); end
        coreDelay = $urandom_range(1, 5);
        doTxn(16'd48, 16'd18, g, e, cyc, lat, hung, sawStart, leak);
        checks++; if (g !== 16'd6 || e !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second: got gcd=%0d err=%b expected gcd=6 err=0", g, e); end
        checks++; if (cyc !== 16'(coreDelay + 1)) begin failures++; $display("[TB] FAIL b2b_cycles: got %0d expected %0d", cyc, coreDelay + 1); end
        finishRsp();
    endtask

    task automatic test_timeout();
        logic [WIDTH-1:0] g;
        logic [15:0]      cyc;
        logic             e;
        int               lat;
        bit               hung, sawStart, leak;
        coreHang = 1'b1;
        doTxn(16'd200, 16'd150, g, e, cyc, lat, hung, sawStart, leak);
        checks++; if (e !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err: got %b expected 1", e); end
        checks++; if (g !== '0) begin failures++; $display("[TB] FAIL timeout_gcd: got %0d expected 0", g); end
        checks++; if (cyc !== 16'(TO)) begin failures++; $display("[TB] FAIL timeout_cycles: got %0d expected %0d", cyc, TO); end
        checks++; if (lat !== SL + 2 + TO + 1) begin failures++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", lat, SL + 2 + TO + 1); end
        checks++; if (gcdStart !== 1'b0 || gcdData !== '0) begin
            failures++; $display("[TB] FAIL timeout_start_drop: got start=%b data=%0d expected start=0 data=0", gcdStart, gcdData);
        end
        finishRsp();
        coreHang = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] g;
        logic [15:0]      cyc;
        logic             e;
        int               lat;
        bit               hung, sawStart, leak;
        coreDelay = $urandom_range(1, 5);
        doTxn(16'd91, 16'd35, g, e, cyc, lat, hung, sawStart, leak);
        checks++; if (g !== 16'd7 || e !== 1'b0) begin failures++; $display("[TB] FAIL hold_result: got gcd=%0d err=%b expected gcd=7 err=0", g, e); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rspValid !== 1'b1 || rspGcd !== 16'd7 || rspErr !== 1'b0 ||
                rspCycles !== 16'(coreDelay + 1) || reqReady !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_stable[%0d]: got valid=%b gcd=%0d err=%b cyc=%0d ready=%b expected 1/7/0/%0d/0",
                         i, rspValid, rspGcd, rspErr, rspCycles, reqReady, coreDelay + 1);
            end
        end
        finishRsp();
    endtask

    task automatic test_reset_mid_wait();
        logic [WIDTH-1:0] g;
        logic [15:0]      cyc;
        logic             e;
        int               lat;
        int               k;
        bit               hung, sawStart, leak;
        coreHang = 1'b1;
        k = 0;
        while (reqReady !== 1'b1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        reqValid = 1'b1; reqA = 16'd143; reqB = 16'd78;
        @(posedge clk); #1;
        reqValid = 1'b0;
        repeat (SL + 4) begin
            @(posedge clk); #1;
        end
        checks++; if (gcdStart !== 1'b1 || gcdData !== 16'd78) begin
            failures++; $display("[TB] FAIL rstwait_in_wait: got start=%b data=%0d expected start=1 data=78", gcdStart, gcdData);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (gcdStart !== 1'b0 || rspValid !== 1'b0 || reqReady !== 1'b1 || rspCycles !== 16'd0) begin
            failures++; $display("[TB] FAIL rstwait_async: got start=%b valid=%b ready=%b cyc=%0d expected 0/0/1/0",
                                 gcdStart, rspValid, reqReady, rspCycles);
        end
        #1 rst = 1'b0;
        coreHang = 1'b0;
        @(posedge clk); #1;
        coreDelay = $urandom_range(1, 5);
        doTxn(16'd100, 16'd75, g, e, cyc, lat, hung, sawStart, leak);
        checks++; if (g !== 16'd25 || e !== 1'b0) begin failures++; $display("[TB] FAIL rstwait_next: got gcd=%0d err=%b expected gcd=25 err=0", g, e); end
        finishRsp();
    endtask

    task automatic test_done_holdoff();
        logic [WIDTH-1:0] g;
        logic [15:0]      cyc;
        logic             e;
        int               lat;
        bit               hung, sawStart, leak;
        coreLinger = 3;
        coreDelay  = 2;
        doTxn(16'd60, 16'd36, g, e, cyc, lat, hung, sawStart, leak);
        checks++; if (g !== 16'd12) begin failures++; $display("[TB] FAIL holdoff_result: got %0d expected 12", g); end
        finishRsp();
        checks++; if (reqReady !== 1'b0) begin failures++; $display("[TB] FAIL holdoff_ready: got %b expected 0", reqReady); end
        reqValid = 1'b1; reqA = 16'd9; reqB = 16'd6;
        @(posedge clk); #1;
        checks++; if (gcdStart !== 1'b0) begin failures++; $display("[TB] FAIL holdoff_no_accept: got start=%b expected 0", gcdStart); end
        reqValid = 1'b0;
        coreLinger = 0;
        doTxn(16'd9, 16'd6, g, e, cyc, lat, hung, sawStart, leak);
        checks++; if (hung || g !== 16'd3) begin failures++; $display("[TB] FAIL holdoff_after: got gcd=%0d expected 3", g); end
        finishRsp();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b, g, expG;
        logic [15:0]      cyc, expCyc;
        logic             e, expE;
        int               lat, expLat;
        bit               hung, sawStart, leak;
        for (int i = 0; i < 12; i++) begin
            a = WIDTH'($urandom_range(1, 250) * $urandom_range(1, 250));
            b = WIDTH'($urandom_range(1, 250) * $urandom_range(1, 250));
            if ($urandom_range(0, 5) == 0) a = '0;
            if ($urandom_range(0, 5) == 0) b = '0;
            coreDelay = $urandom_range(1, 5);
            if (a == 0 || b == 0) begin
                expG = '0; expE = 1'b1; expCyc = 16'd0; expLat = 1;
            end else begin
                expG = refGcd(a, b); expE = 1'b0;
                expCyc = 16'(coreDelay + 1); expLat = SL + 2 + coreDelay + 1 + 1;
            end
            doTxn(a, b, g, e, cyc, lat, hung, sawStart, leak);
            checks++; if (g !== expG || e !== expE) begin
                failures++; $display("[TB] FAIL rand_result[%0d] (%0d,%0d): got gcd=%0d err=%b expected gcd=%0d err=%b", i, a, b, g, e, expG, expE);
            end
            checks++; if (cyc !== expCyc || lat !== expLat) begin
                failures++; $display("[TB] FAIL rand_timing[%0d]: got cyc=%0d lat=%0d expected cyc=%0d lat=%0d", i, cyc, lat, expCyc, expLat);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            finishRsp();
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #20 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_normal();
        test_zero_operands();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        test_done_holdoff();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
